// File: rtl/scan_display.sv
// Time-multiplexed 7-segment display driver: scans DIGITS digits, snapshots the
// input data once per frame and blinks the digits under adjustment.
module scan_display #(
    parameter int DIGITS         = 8,
    parameter int SCAN_DIV       = 1,
    parameter int BLINK_DIV      = 250,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                  CP_1KHz,
    input  logic                  _CR,
    input  logic [4*DIGITS-1:0]   display_time,
    input  logic [DIGITS-1:0]     index,
    input  logic                  adjust,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [DIGITS-1:0]     select_light,
    output logic [7:0]            display_char,
    output logic                  frame_start
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DIGITS);
    localparam int BW = $clog2(BLINK_DIV);

    localparam logic [PW-1:0]     PRE_MAX   = PW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]     SCAN_MAX  = SW'(DIGITS - 1);
    localparam logic [BW-1:0]     BLINK_MAX = BW'(BLINK_DIV - 1);
    localparam logic [7:0]        SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_OFF   = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

    logic [PW-1:0]       prescaler;
    logic [SW-1:0]       scan_idx;
    logic [BW-1:0]       blink_cnt;
    logic                blink_phase;
    logic [4*DIGITS-1:0] time_sh;
    logic [DIGITS-1:0]   index_sh;
    logic                adjust_sh;
    logic [DIGITS-1:0]   dp_sh;

    logic                fs_p0;
    logic [4*DIGITS-1:0] time_p0;
    logic [DIGITS-1:0]   index_p0;
    logic                adjust_p0;
    logic [DIGITS-1:0]   dp_p0;
    logic [3:0]          nib_p0;
    logic                blank_p0;
    logic [7:0]          seg_p0;
    logic [DIGITS-1:0]   sel_p0;

    // Stage p0: decode the current slot; frame-start slots bypass the shadows
    always_comb begin
        fs_p0     = (scan_idx == '0) && (prescaler == '0);
        time_p0   = fs_p0 ? display_time : time_sh;
        index_p0  = fs_p0 ? index        : index_sh;
        adjust_p0 = fs_p0 ? adjust       : adjust_sh;
        dp_p0     = fs_p0 ? dp_mask      : dp_sh;
        nib_p0    = time_p0[{scan_idx, 2'b00} +: 4];
        blank_p0  = adjust_p0 & index_p0[scan_idx] & blink_phase;
        seg_p0    = blank_p0 ? 8'h00 : {dp_p0[scan_idx], seg7(nib_p0)};
        sel_p0    = '0;
        sel_p0[scan_idx] = 1'b1;
    end

    always_ff @(posedge CP_1KHz or posedge _CR) begin
        if (_CR) begin
            prescaler   <= '0;
            scan_idx    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            time_sh     <= '0;
            index_sh    <= '0;
            adjust_sh   <= 1'b0;
            dp_sh       <= '0;
        end else begin
            if (prescaler == PRE_MAX) begin
                prescaler <= '0;
                scan_idx  <= (scan_idx == SCAN_MAX) ? '0 : scan_idx + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            if (fs_p0) begin
                time_sh   <= display_time;
                index_sh  <= index;
                adjust_sh <= adjust;
                dp_sh     <= dp_mask;
            end
        end
    end

    // Stage p1: output registers, polarity applied here only
    always_ff @(posedge CP_1KHz or posedge _CR) begin
        if (_CR) begin
            select_light <= SEL_OFF;
            display_char <= SEG_OFF;
            frame_start  <= 1'b0;
        end else begin
            select_light <= sel_p0 ^ SEL_OFF;
            display_char <= seg_p0 ^ SEG_OFF;
            frame_start  <= fs_p0;
        end
    end

endmodule

// File: tb/tb_scan_display.sv
// Directed bench for scan_display: reset, scan order, frame snapshot,
// mid-frame reset, blinking and dp/hex decode with active-low outputs.
module tb_scan_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] display_time = 32'h0;
    logic [7:0]  index = 8'h0;
    logic        adjust = 1'b0;
    logic [7:0]  dp_mask = 8'h0;
    logic [7:0]  select_light;
    logic [7:0]  display_char;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    // Active-low patterns for digits 0..7 of 32'h12345678 (nibbles 8,7,6,5,4,3,2,1)
    logic [7:0] char_tbl [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] snap_tbl [5] = '{8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    scan_display #(
        .DIGITS(8), .SCAN_DIV(1), .BLINK_DIV(8), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) dut (
        .CP_1KHz(clk),
        ._CR(rst),
        .display_time(display_time),
        .index(index),
        .adjust(adjust),
        .dp_mask(dp_mask),
        .select_light(select_light),
        .display_char(display_char),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] sel, input logic [7:0] chr,
                           input logic fs);
        chk({tag, ".sel"}, select_light, sel);
        chk({tag, ".char"}, display_char, chr);
        chk({tag, ".fs"}, {7'b0, frame_start}, {7'b0, fs});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Asynchronous reset with no clock edge in between
        #1 rst = 1'b1;
        #1 chk_all("reset", 8'hFF, 8'hFF, 1'b0);

        // Scan with adjust=0: index bits must not blank anything
        display_time = 32'h12345678;
        index = 8'hFF;
        adjust = 1'b0;
        dp_mask = 8'h00;
        release_reset();
        step();
        chk_all("scan_e0", 8'hFE, 8'h80, 1'b1);
        for (int k = 1; k < 8; k++) begin
            step();
            chk_all($sformatf("scan_e%0d", k), ~(8'h01 << k), char_tbl[k], 1'b0);
        end
        step();
        chk_all("scan_e8", 8'hFE, 8'h80, 1'b1);

        // Snapshot: new data mid-frame must wait for the next frame
        step();
        step();
        display_time = 32'h00000000;
        for (int k = 3; k < 8; k++) begin
            step();
            chk_all($sformatf("snap_e%0d", k + 8), ~(8'h01 << k), snap_tbl[k - 3], 1'b0);
        end
        step();
        chk_all("snap_e16", 8'hFE, 8'hC0, 1'b1);

        // Reset mid-frame, between digit 5 and digit 6
        display_time = 32'h12345678;
        for (int k = 1; k <= 5; k++) step();
        chk("pre_rst.sel", select_light, 8'hDF);
        #2 rst = 1'b1;
        #1 chk_all("midrst", 8'hFF, 8'hFF, 1'b0);

        // Blink on digit 0 only
        adjust = 1'b1;
        index = 8'h01;
        release_reset();
        step();
        chk_all("blink_e0", 8'hFE, 8'h80, 1'b1);
        for (int k = 1; k < 8; k++) step();
        chk("blink_e7.char", display_char, 8'hF9);
        step();
        chk_all("blink_e8", 8'hFE, 8'hFF, 1'b1);
        for (int k = 1; k < 8; k++) begin
            step();
            chk($sformatf("blink_e%0d.char", k + 8), display_char, char_tbl[k]);
        end
        step();
        chk_all("blink_e16", 8'hFE, 8'h80, 1'b1);

        // adjust=1 with index=0: steady display during blink phase
        rst = 1'b1;
        index = 8'h00;
        release_reset();
        for (int k = 0; k < 9; k++) step();
        chk_all("steady_e8", 8'hFE, 8'h80, 1'b1);

        // Hex A with decimal point, then blanked including dp
        rst = 1'b1;
        display_time = 32'h1234567A;
        dp_mask = 8'h01;
        index = 8'h01;
        release_reset();
        step();
        chk_all("dphex_e0", 8'hFE, 8'h08, 1'b1);
        step();
        chk("dphex_e1.char", display_char, 8'hF8);
        for (int k = 2; k < 9; k++) step();
        chk_all("dphex_e8", 8'hFE, 8'hFF, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
